// File: rtl/mld_15_7_type1_decoder_if.sv
// rtl/mld_15_7_type1_decoder_if.sv - serial in/out bundle for the (15,7) majority-logic decoder
interface mld_15_7_type1_decoder_if;
   logic       received_bit;
   logic       in_valid;
   logic       in_ready;
   logic       decoded_bit;
   logic       out_valid;
   logic       out_first;
   logic       out_last;
   logic       out_is_info;
   logic [3:0] corrected_count;
   logic       uncorrectable;

   modport master (
      output received_bit, in_valid,
      input  in_ready, decoded_bit, out_valid, out_first, out_last, out_is_info,
             corrected_count, uncorrectable
   );

   modport slave (
      input  received_bit, in_valid,
      output in_ready, decoded_bit, out_valid, out_first, out_last, out_is_info,
             corrected_count, uncorrectable
   );
endinterface

// File: rtl/mld_15_7_type1_decoder.sv
// rtl/mld_15_7_type1_decoder.sv - serial Type I majority-logic decoder, (15,7) code, g(x)=1+x^4+x^6+x^7+x^8
module mld_15_7_type1_decoder #(
   parameter int MAJ_THRESHOLD = 3
) (
   input  logic clk,
   input  logic reset,
   mld_15_7_type1_decoder_if.slave dec_if
);
   typedef enum logic {LOAD = 1'b0, DECODE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  syn_q, syn_d;
   logic [14:0] buf_q, buf_d;
   logic [3:0]  corr_run_q, corr_run_d;
   logic        in_ready_q, in_ready_d;
   logic        dec_bit_q, dec_bit_d;
   logic        out_valid_q, out_valid_d;
   logic        out_first_q, out_first_d;
   logic        out_last_q, out_last_d;
   logic        out_info_q, out_info_d;
   logic [3:0]  corr_cnt_q, corr_cnt_d;
   logic        unc_q, unc_d;

   logic        accept, last_bit, e;
   logic [2:0]  votes;
   logic [7:0]  syn_shift_e;

   // One step of division by g(x): s <- (s*x + d) mod g
   function automatic logic [7:0] div_step(input logic [7:0] s, input logic d);
      return {s[6] ^ s[7], s[5] ^ s[7], s[4], s[3] ^ s[7], s[2], s[1], s[0], s[7] ^ d};
   endfunction

   assign accept   = dec_if.in_valid & in_ready_q;
   assign last_bit = (bit_cnt_q == 4'd14);

   assign votes = {2'b00, syn_q[7]} + {2'b00, syn_q[3]} + {2'b00, syn_q[1] ^ syn_q[5]}
                + {2'b00, syn_q[0] ^ syn_q[2] ^ syn_q[6]};
   assign e           = (int'(votes) >= MAJ_THRESHOLD);
   assign syn_shift_e = div_step(syn_q, e);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LOAD;
         bit_cnt_q   <= '0;
         syn_q       <= '0;
         buf_q       <= '0;
         corr_run_q  <= '0;
         in_ready_q  <= 1'b1;
         dec_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_info_q  <= 1'b0;
         corr_cnt_q  <= '0;
         unc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         syn_q       <= syn_d;
         buf_q       <= buf_d;
         corr_run_q  <= corr_run_d;
         in_ready_q  <= in_ready_d;
         dec_bit_q   <= dec_bit_d;
         out_valid_q <= out_valid_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
         out_info_q  <= out_info_d;
         corr_cnt_q  <= corr_cnt_d;
         unc_q       <= unc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (accept && last_bit) state_d = DECODE;
         DECODE:  if (last_bit) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      syn_d       = syn_q;
      buf_d       = buf_q;
      corr_run_d  = corr_run_q;
      in_ready_d  = in_ready_q;
      dec_bit_d   = dec_bit_q;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      out_info_d  = 1'b0;
      corr_cnt_d  = corr_cnt_q;
      unc_d       = unc_q;
      case (state_q)
         LOAD: begin
            if (accept) begin
               buf_d = {buf_q[13:0], dec_if.received_bit};
               syn_d = div_step(syn_q, dec_if.received_bit);
               if (last_bit) begin
                  bit_cnt_d  = '0;
                  in_ready_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         DECODE: begin
            dec_bit_d   = buf_q[14] ^ e;
            out_valid_d = 1'b1;
            out_first_d = (bit_cnt_q == 4'd0);
            out_info_d  = (bit_cnt_q < 4'd7);
            out_last_d  = last_bit;
            buf_d       = {buf_q[13:0], 1'b0};
            syn_d       = syn_shift_e;
            corr_run_d  = corr_run_q + {3'b000, e};
            bit_cnt_d   = bit_cnt_q + 4'd1;
            if (last_bit) begin
               corr_cnt_d = corr_run_q + {3'b000, e};
               unc_d      = (syn_shift_e != 8'd0);
               // Residual syndrome would otherwise leak into the next block's division
               syn_d      = '0;
               corr_run_d = '0;
               bit_cnt_d  = '0;
               in_ready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign dec_if.in_ready        = in_ready_q;
   assign dec_if.decoded_bit     = dec_bit_q;
   assign dec_if.out_valid       = out_valid_q;
   assign dec_if.out_first       = out_first_q;
   assign dec_if.out_last        = out_last_q;
   assign dec_if.out_is_info     = out_info_q;
   assign dec_if.corrected_count = corr_cnt_q;
   assign dec_if.uncorrectable   = unc_q;
endmodule

// File: tb/tb_mld_15_7_type1_decoder.sv
// tb/tb_mld_15_7_type1_decoder.sv - randomized self-checking bench for mld_15_7_type1_decoder
module tb_mld_15_7_type1_decoder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mld_15_7_type1_decoder_if dif ();

   mld_15_7_type1_decoder #(.MAJ_THRESHOLD(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .dec_if (dif.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [14:0] exp_word_q[$];
   logic [3:0]  exp_cnt_q[$];
   logic        exp_unc_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Remainder of r(x) divided by g(x) = x^8+x^7+x^6+x^4+1, as an 8-bit polynomial
   function automatic logic [7:0] poly_mod(input logic [14:0] r);
      logic [15:0] v;
      v = {1'b0, r};
      for (int b = 14; b >= 8; b--)
         if (v[b]) v = v ^ (16'h01D1 << (b - 8));
      return v[7:0];
   endfunction

   function automatic logic [14:0] codeword(input logic [6:0] info);
      return {info, poly_mod({info, 8'h00})};
   endfunction

   function automatic logic [14:0] rand_err(input int w);
      logic [14:0] m;
      m = '0;
      while ($countones(m) < w) m[$urandom_range(0, 14)] = 1'b1;
      return m;
   endfunction

   // Majority-vote decoding expressed on polynomials: test bit 14 of the current
   // cyclic shift, fold the decision into the syndrome, rotate by x.
   task automatic model_decode(input logic [14:0] r, output logic [14:0] w,
                               output logic [3:0] c, output logic u);
      logic [8:0] s;
      int votes;
      logic e;
      s = {1'b0, poly_mod(r)};
      w = '0;
      c = '0;
      for (int i = 0; i < 15; i++) begin
         votes = int'(s[7]) + int'(s[3]) + int'(s[1] ^ s[5]) + int'(s[0] ^ s[2] ^ s[6]);
         e = (votes >= 3);
         w[14 - i] = r[14 - i] ^ e;
         c = c + 4'(e);
         s = {s[7:0], 1'b0} ^ {8'h00, e};
         if (s[8]) s = s ^ 9'h1D1;
      end
      u = (s != 9'd0);
   endtask

   task automatic send_block(input logic [14:0] rx, input logic [14:0] exp_w,
                             input logic [3:0] exp_c, input logic exp_u, input bit gaps);
      int  i = 0;
      int  guard = 0;
      bit  acc;
      exp_word_q.push_back(exp_w);
      exp_cnt_q.push_back(exp_c);
      exp_unc_q.push_back(exp_u);
      while (i < 15 && guard < 300) begin
         dif.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         acc = dif.in_valid && dif.in_ready;
         dif.received_bit = acc ? rx[14 - i] : 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (acc) i++;
         guard++;
      end
      if (i < 15) begin
         check("accept_timeout", i, 15);
         return;
      end
      dif.in_valid = 1'b0;
      check("lat_pre_valid", dif.out_valid, 0);
      @(posedge clk);
      #1;
      check("lat_valid", dif.out_valid, 1);
      check("lat_first", dif.out_first, 1);
   endtask

   int          pos = 0;
   logic [14:0] got_word;

   always @(negedge clk) begin
      if (reset) begin
         pos = 0;
      end else begin
         if (pos != 0) check("valid_run", dif.out_valid, 1);
         if (pos == 0 && exp_word_q.size() == 0) check("stale_valid", dif.out_valid, 0);
         if (dif.out_valid) begin
            check("first_mark", dif.out_first, 32'(pos == 0));
            check("info_mark", dif.out_is_info, 32'(pos < 7));
            check("last_mark", dif.out_last, 32'(pos == 14));
            check("in_ready_dec", dif.in_ready, 32'(pos == 14));
            got_word = {got_word[13:0], dif.decoded_bit};
            if (pos == 14 && exp_word_q.size() != 0) begin
               check("word", got_word, exp_word_q.pop_front());
               check("corr_count", dif.corrected_count, exp_cnt_q.pop_front());
               check("uncorr", dif.uncorrectable, exp_unc_q.pop_front());
            end
            pos = (pos == 14) ? 0 : pos + 1;
         end
      end
   end

   initial begin
      logic [14:0] cw, em, mw;
      logic [3:0]  mc;
      logic        mu;
      int          w;
      int          guard;

      reset = 1'b1;
      dif.in_valid = 1'b0;
      dif.received_bit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", dif.in_ready, 1);
      check("rst_out_valid", dif.out_valid, 0);
      check("rst_dec_bit", dif.decoded_bit, 0);
      check("rst_first", dif.out_first, 0);
      check("rst_last", dif.out_last, 0);
      check("rst_info", dif.out_is_info, 0);
      check("rst_count", dif.corrected_count, 0);
      check("rst_uncorr", dif.uncorrectable, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      send_block(15'h40E8, 15'h40E8, 4'd0, 1'b0, 1'b0);
      send_block(15'h00E0, 15'h40E8, 4'd2, 1'b0, 1'b0);
      send_block(15'h4069, 15'h40E8, 4'd2, 1'b0, 1'b0);
      send_block(15'h40E8, 15'h40E8, 4'd0, 1'b0, 1'b1);

      for (int k = 0; k < 128; k++) begin
         cw = codeword(7'(k));
         w  = $urandom_range(0, 2);
         em = rand_err(w);
         send_block(cw ^ em, cw, 4'(w), 1'b0, bit'(k[0]));
      end

      for (int k = 0; k < 700; k++) begin
         cw = codeword(7'($urandom_range(0, 127)));
         w  = $urandom_range(0, 2);
         em = rand_err(w);
         send_block(cw ^ em, cw, 4'(w), 1'b0, bit'($urandom_range(0, 1)));
      end

      model_decode(15'h7000, mw, mc, mu);
      send_block(15'h7000, mw, mc, mu, 1'b0);
      for (int k = 0; k < 60; k++) begin
         cw = codeword(7'($urandom_range(0, 127))) ^ rand_err($urandom_range(3, 5));
         model_decode(cw, mw, mc, mu);
         send_block(cw, mw, mc, mu, bit'($urandom_range(0, 1)));
      end

      guard = 0;
      while (exp_word_q.size() != 0 && guard < 60) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check("drain_before_reset", exp_word_q.size(), 0);

      send_block(15'h40E8, 15'h40E8, 4'd0, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_word_q.delete();
      exp_cnt_q.delete();
      exp_unc_q.delete();
      #1;
      check("abort_out_valid", dif.out_valid, 0);
      check("abort_in_ready", dif.in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      send_block(15'h40E8, 15'h40E8, 4'd0, 1'b0, 1'b1);

      guard = 0;
      while (exp_word_q.size() != 0 && guard < 60) begin
         @(posedge clk);
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("drain_final", exp_word_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
